// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bundle between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, runs one outstanding imem transaction
// and presents a single fetched instruction with a valid flag to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        breakpoint,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    if_fetch_if.master  imem,
    output logic [31:0] pc_plus4,
    output logic [31:0] ins_out,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] ins_q, ins_d;
    logic        valid_q, valid_d;
    logic        squash_q, squash_d;

    logic [31:0] target;
    logic        consume;

    assign target  = redirect_pc & ~32'h3;
    assign consume = valid_q && !stall && !breakpoint;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        pc_plus4_d = pc_plus4_q;
        ins_d      = ins_q;
        valid_d    = valid_q;
        squash_d   = squash_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = target;
                end else if (!breakpoint) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect without ack keeps the bus request alive but marks
                // the returning data stale so it is dropped on arrival.
                if (redirect && imem.imem_ack) begin
                    pc_d     = target;
                    req_d    = 1'b0;
                    squash_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (redirect) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end else if (imem.imem_ack && squash_q) begin
                    req_d    = 1'b0;
                    squash_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (imem.imem_ack) begin
                    ins_d      = imem.imem_rdata;
                    pc_plus4_d = pc_q + 32'd4;
                    pc_d       = pc_q + 32'd4;
                    valid_d    = 1'b1;
                    req_d      = 1'b0;
                    state_d    = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = S_IDLE;
                end else if (consume) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            pc_plus4_q <= '0;
            ins_q      <= '0;
            valid_q    <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc_plus4_q <= pc_plus4_d;
            ins_q      <= ins_d;
            valid_q    <= valid_d;
            squash_q   <= squash_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc_plus4       = pc_plus4_q;
    assign ins_out        = ins_q;
    assign if_valid       = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// compared against a program-order instruction-stream model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PAT      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, stall, breakpoint, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4, ins_out;
    logic        if_valid;

    always #5 clk = ~clk;

    if_fetch_if imem_bus();

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .breakpoint (breakpoint),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem       (imem_bus),
        .pc_plus4   (pc_plus4),
        .ins_out    (ins_out),
        .if_valid   (if_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the address of the next instruction in program order.
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] obs_p4_q[$], obs_ins_q[$], exp_p4_q[$], exp_ins_q[$];
    logic [31:0] obs_req_q[$], exp_req_q[$];
    int          cons_cyc_q[$];
    int          contract_err = 0;
    bit          req_rose = 1'b0;

    bit mem_auto  = 1'b1;
    bit man_ack   = 1'b0;
    int fixed_lat = 0;
    int lat       = 1;
    int req_age   = 0;

    // One clock: memory responder, consumption/redirect model, bus-contract monitor.
    task automatic step();
        logic        p_req, ack_now, cons, bp_at, rd_at, rst_at;
        logic [31:0] p_addr;
        p_req  = imem_bus.imem_req;
        p_addr = imem_bus.imem_addr;
        if (mem_auto) ack_now = p_req && (req_age + 1 >= lat);
        else          ack_now = man_ack;
        imem_bus.imem_ack   = ack_now;
        imem_bus.imem_rdata = p_req ? (p_addr ^ PAT) : $urandom();
        cons = if_valid && !stall && !breakpoint && !redirect && !rst;
        if (cons) begin
            obs_p4_q.push_back(pc_plus4);
            obs_ins_q.push_back(ins_out);
            exp_p4_q.push_back(exp_addr + 32'd4);
            exp_ins_q.push_back(exp_addr ^ PAT);
            cons_cyc_q.push_back(cyc);
            exp_addr = exp_addr + 32'd4;
        end
        if (rst)           exp_addr = RESET_PC;
        else if (redirect) exp_addr = redirect_pc & ~32'h3;
        bp_at  = breakpoint;
        rd_at  = redirect;
        rst_at = rst;
        @(posedge clk);
        #1;
        cyc++;
        man_ack  = 1'b0;
        req_rose = imem_bus.imem_req && !p_req;
        if (req_rose) begin
            obs_req_q.push_back(imem_bus.imem_addr);
            exp_req_q.push_back(exp_addr);
            if (bp_at || rd_at) contract_err++;
        end
        if (!rst_at && p_req && imem_bus.imem_req && imem_bus.imem_addr !== p_addr) contract_err++;
        if (!rst_at && p_req && !imem_bus.imem_req && !ack_now) contract_err++;
        if (imem_bus.imem_req && if_valid) contract_err++;
        if (!imem_bus.imem_req || ack_now) begin
            req_age = 0;
            lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        end else if (p_req) begin
            req_age++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; breakpoint = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_auto = 1'b1; fixed_lat = 0; man_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        obs_p4_q.delete(); obs_ins_q.delete(); exp_p4_q.delete(); exp_ins_q.delete();
        obs_req_q.delete(); exp_req_q.delete(); cons_cyc_q.delete();
        contract_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; breakpoint = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        n_checks++; if (imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_bus.imem_addr); end
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want 0", pc_plus4); end
        n_checks++; if (ins_out !== 32'h0) begin n_fail++; $display("FAIL reset_ins_out: got %h want 0", ins_out); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        fixed_lat = 1; lat = 1; req_age = 0;
        for (int i = 0; i < 40 && obs_p4_q.size() < 3; i++) step();
        n_checks++;
        if (obs_p4_q.size() != 3 || obs_req_q.size() < 3) begin
            n_fail++; $display("FAIL seq_timeout: got %0d captures want 3", obs_p4_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (obs_req_q[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, obs_req_q[i], 32'(4 * i)); end
                n_checks++; if (obs_p4_q[i] !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_pc_plus4[%0d]: got %h want %h", i, obs_p4_q[i], 32'(4 * (i + 1))); end
                n_checks++; if (obs_ins_q[i] !== (32'(4 * i) ^ PAT)) begin n_fail++; $display("FAIL seq_ins[%0d]: got %h want %h", i, obs_ins_q[i], 32'(4 * i) ^ PAT); end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++; if (cons_cyc_q[i] - cons_cyc_q[i-1] != 3) begin n_fail++; $display("FAIL seq_spacing[%0d]: got %0d want 3", i, cons_cyc_q[i] - cons_cyc_q[i-1]); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 20 && !if_valid; i++) step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_wait_valid: got %b want 1", if_valid); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_valid); end
            n_checks++; if (pc_plus4 !== exp_addr + 32'd4) begin n_fail++; $display("FAIL stall_pc_plus4[%0d]: got %h want %h", i, pc_plus4, exp_addr + 32'd4); end
            n_checks++; if (ins_out !== (exp_addr ^ PAT)) begin n_fail++; $display("FAIL stall_ins[%0d]: got %h want %h", i, ins_out, exp_addr ^ PAT); end
            n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_bus.imem_req); end
        end
        stall = 1'b0;
        step();
        for (int i = 0; i < 10 && !req_rose; i++) step();
        n_checks++; if (!req_rose || imem_bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_next_addr: got %h want 00000004", imem_bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_auto = 1'b0;
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rdw_issue: got %b want 1", imem_bus.imem_req); end
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rdw_hold: got req=%b addr=%h want req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr); end
        step();
        step();
        man_ack = 1'b1;
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_req_drop: got %b want 0", imem_bus.imem_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_discard: got %b want 0", if_valid); end
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_refetch: got req=%b addr=%h want req=1 addr=100", imem_bus.imem_req, imem_bus.imem_addr); end
        man_ack = 1'b1;
        step();
        n_checks++; if (if_valid !== 1'b1 || pc_plus4 !== 32'h104 || ins_out !== (32'h100 ^ PAT)) begin n_fail++; $display("FAIL rdw_capture: got v=%b p4=%h ins=%h want v=1 p4=104 ins=%h", if_valid, pc_plus4, ins_out, 32'h100 ^ PAT); end
    endtask

    task automatic test_redirect_ack();
        int n;
        do_reset();
        mem_auto = 1'b0;
        step();
        step();
        man_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rda_discard: got req=%b v=%b want 0 0", imem_bus.imem_req, if_valid); end
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL rda_addr: got req=%b addr=%h want req=1 addr=200", imem_bus.imem_req, imem_bus.imem_addr); end
        man_ack = 1'b1;
        step();
        n_checks++; if (if_valid !== 1'b1 || pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL rda_capture: got v=%b p4=%h want v=1 p4=204", if_valid, pc_plus4); end
        n = obs_p4_q.size();
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rda_full_drop: got %b want 0", if_valid); end
        n_checks++; if (obs_p4_q.size() != n) begin n_fail++; $display("FAIL rda_no_capture: got %0d captures want %0d", obs_p4_q.size(), n); end
        n_checks++; if (pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL rda_p4_kept: got %h want 204", pc_plus4); end
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h300) begin n_fail++; $display("FAIL rda_refetch: got req=%b addr=%h want req=1 addr=300", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        mem_auto = 1'b0;
        breakpoint = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_idle_req[%0d]: got %b want 0", i, imem_bus.imem_req); end
        end
        breakpoint = 1'b0;
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL bp_release: got req=%b addr=%h want req=1 addr=40", imem_bus.imem_req, imem_bus.imem_addr); end
        breakpoint = 1'b1; man_ack = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (if_valid !== 1'b1 || pc_plus4 !== 32'h44 || imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold[%0d]: got v=%b p4=%h req=%b want v=1 p4=44 req=0", i, if_valid, pc_plus4, imem_bus.imem_req); end
            step();
        end
        breakpoint = 1'b0;
        step();
        n_checks++; if (if_valid !== 1'b0 || obs_p4_q.size() != 1) begin n_fail++; $display("FAIL bp_consume: got v=%b captures=%0d want v=0 captures=1", if_valid, obs_p4_q.size()); end
        step();
        n_checks++; if (imem_bus.imem_addr !== 32'h44) begin n_fail++; $display("FAIL bp_next_addr: got %h want 44", imem_bus.imem_addr); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        mem_auto = 1'b0;
        step();
        man_ack = 1'b1;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0 || pc_plus4 !== 32'h0 || ins_out !== 32'h0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL midwait_reset: got req=%b addr=%h p4=%h ins=%h v=%b want all 0", imem_bus.imem_req, imem_bus.imem_addr, pc_plus4, ins_out, if_valid); end
        man_ack = 1'b1;
        step();
        n_checks++; if (if_valid !== 1'b0 || ins_out !== 32'h0) begin n_fail++; $display("FAIL midwait_ack_ignored: got v=%b ins=%h want v=0 ins=0", if_valid, ins_out); end
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL midwait_refetch: got req=%b addr=%h want req=1 addr=%h", imem_bus.imem_req, imem_bus.imem_addr, RESET_PC); end
        man_ack = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        n_checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", imem_bus.imem_addr); end
        man_ack = 1'b1;
        step();
        n_checks++; if (if_valid !== 1'b1 || pc_plus4 !== 32'h0 || ins_out !== (32'hFFFF_FFFC ^ PAT)) begin n_fail++; $display("FAIL wrap_capture: got v=%b p4=%h ins=%h want v=1 p4=0 ins=%h", if_valid, pc_plus4, ins_out, 32'hFFFF_FFFC ^ PAT); end
        step();
        step();
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got req=%b addr=%h want req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 99) < 30);
            breakpoint  = ($urandom_range(0, 99) < 8);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = $urandom();
            step();
        end
        stall = 1'b0; breakpoint = 1'b0; redirect = 1'b0;
        n_checks++; if (obs_p4_q.size() < 50 || obs_p4_q.size() != exp_p4_q.size()) begin n_fail++; $display("FAIL rand_capture_count: got %0d want %0d (>=50)", obs_p4_q.size(), exp_p4_q.size()); end
        for (int i = 0; i < obs_p4_q.size() && i < exp_p4_q.size(); i++) begin
            n_checks++; if (obs_p4_q[i] !== exp_p4_q[i] || obs_ins_q[i] !== exp_ins_q[i]) begin n_fail++; $display("FAIL rand_capture[%0d]: got p4=%h ins=%h want p4=%h ins=%h", i, obs_p4_q[i], obs_ins_q[i], exp_p4_q[i], exp_ins_q[i]); end
        end
        for (int i = 0; i < obs_req_q.size(); i++) begin
            n_checks++; if (obs_req_q[i] !== exp_req_q[i]) begin n_fail++; $display("FAIL rand_req_addr[%0d]: got %h want %h", i, obs_req_q[i], exp_req_q[i]); end
        end
        n_checks++; if (contract_err != 0) begin n_fail++; $display("FAIL rand_bus_contract: got %0d violations want 0", contract_err); end
    endtask

    initial begin
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_breakpoint();
        test_reset_midwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
